// File: rtl/quantize_pipe_pkg.sv
// Shared widths and constants for the quantize pipeline and its lanes.
package quantize_pipe_pkg;

    localparam int unsigned DEF_ARRAY_SIZE        = 8;
    localparam int unsigned DEF_DATA_WIDTH        = 8;
    localparam int unsigned DEF_CUM_BITS_EXT      = 5;
    localparam int unsigned DEF_OUTPUT_DATA_WIDTH = 16;
    localparam int unsigned DEF_SHIFT_WIDTH       = 4;

    localparam logic signed [DEF_OUTPUT_DATA_WIDTH-1:0] OUT_MAX = 16'sh7FFF;
    localparam logic signed [DEF_OUTPUT_DATA_WIDTH-1:0] OUT_MIN = 16'sh8000;

    localparam int unsigned            SAT_CNT_W   = 16;
    localparam logic [SAT_CNT_W-1:0]   SAT_CNT_MAX = '1;

endpackage

// File: rtl/quantize_lane.sv
// One lane: S1 round-half-up arithmetic right shift, S2 optional ReLU and saturation.
module quantize_lane #(
    parameter int unsigned ORI_WIDTH         = 21,
    parameter int unsigned OUTPUT_DATA_WIDTH = 16,
    parameter int unsigned SHIFT_WIDTH       = 4
) (
    input  logic [ORI_WIDTH-1:0]         i_x,
    input  logic [SHIFT_WIDTH-1:0]       i_shift,
    output logic [ORI_WIDTH:0]           o_shifted,
    input  logic [ORI_WIDTH:0]           i_shifted,
    input  logic                         i_relu,
    output logic [OUTPUT_DATA_WIDTH-1:0] o_q,
    output logic                         o_sat
);

    localparam int unsigned W1 = ORI_WIDTH + 1;
    localparam logic signed [W1-1:0] MAX_V = W1'((64'sd1 <<< (OUTPUT_DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [W1-1:0] MIN_V = ~MAX_V;

    logic signed [W1-1:0] w_x;
    logic signed [W1-1:0] w_rnd;
    logic signed [W1-1:0] w_sum;
    logic signed [W1-1:0] w_v;

    always_comb begin
        w_x       = W1'($signed(i_x));
        w_rnd     = '0;
        w_sum     = '0;
        o_shifted = w_x;
        if (i_shift == '0) begin
            o_shifted = w_x;
        end else if (32'(i_shift) >= ORI_WIDTH) begin
            // Everything shifted out: only the sign survives.
            o_shifted = {W1{w_x[W1-1]}};
        end else begin
            w_rnd     = W1'(1) << (i_shift - SHIFT_WIDTH'(1));
            w_sum     = w_x + w_rnd;
            o_shifted = w_sum >>> i_shift;
        end
    end

    always_comb begin
        w_v = $signed(i_shifted);
        if (i_relu && w_v[W1-1]) begin
            w_v = '0;
        end
        o_sat = 1'b0;
        o_q   = w_v[OUTPUT_DATA_WIDTH-1:0];
        if (w_v > MAX_V) begin
            o_q   = MAX_V[OUTPUT_DATA_WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_v < MIN_V) begin
            o_q   = MIN_V[OUTPUT_DATA_WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/quantize_pipe.sv
// Two-stage valid/ready quantizer: S1 round/shift, S2 ReLU/saturate, plus sticky sat counter.
module quantize_pipe
    import quantize_pipe_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE        = DEF_ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned CUM_BITS_EXT      = DEF_CUM_BITS_EXT,
    parameter int unsigned ORI_WIDTH         = DATA_WIDTH * 2 + CUM_BITS_EXT,
    parameter int unsigned OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
    parameter int unsigned SHIFT_WIDTH       = DEF_SHIFT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]       ori_data,
    input  logic [SHIFT_WIDTH-1:0]                shift_amt,
    input  logic                                  relu_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
    output logic [SAT_CNT_W-1:0]                  sat_cnt,
    input  logic                                  sat_clr
);

    localparam int unsigned W1    = ORI_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(ARRAY_SIZE + 1);
    localparam int unsigned SUM_W = SAT_CNT_W + 1;

    logic                                   r_s1_valid;
    logic                                   r_s1_relu;
    logic [ARRAY_SIZE*W1-1:0]               r_s1_data;
    logic [ARRAY_SIZE*W1-1:0]               w_s1_data;
    logic                                   r_out_valid;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] r_out_data;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] w_out_data;
    logic [CNT_W-1:0]                       r_out_nsat;
    logic [CNT_W-1:0]                       w_nsat;
    logic [ARRAY_SIZE-1:0]                  w_sat;
    logic [SAT_CNT_W-1:0]                   r_sat_cnt;
    logic [SAT_CNT_W-1:0]                   w_sat_cnt;
    logic [SUM_W-1:0]                       w_sum;
    logic                                   w_out_load;
    logic                                   w_out_fire;

    assign w_out_fire     = r_out_valid && out_ready;
    assign w_out_load     = !r_out_valid || out_ready;
    assign in_ready       = !r_s1_valid || w_out_load;
    assign out_valid      = r_out_valid;
    assign quantized_data = r_out_data;
    assign sat_cnt        = r_sat_cnt;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        quantize_lane #(
            .ORI_WIDTH         (ORI_WIDTH),
            .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
            .SHIFT_WIDTH       (SHIFT_WIDTH)
        ) u_lane (
            .i_x       (ori_data[i*ORI_WIDTH +: ORI_WIDTH]),
            .i_shift   (shift_amt),
            .o_shifted (w_s1_data[i*W1 +: W1]),
            .i_shifted (r_s1_data[i*W1 +: W1]),
            .i_relu    (r_s1_relu),
            .o_q       (w_out_data[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]),
            .o_sat     (w_sat[i])
        );
    end

    always_comb begin
        w_nsat = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_nsat = w_nsat + CNT_W'(w_sat[i]);
        end
    end

    always_comb begin
        w_sum     = {1'b0, r_sat_cnt} + SUM_W'(r_out_nsat);
        w_sat_cnt = r_sat_cnt;
        if (sat_clr) begin
            w_sat_cnt = w_out_fire ? SAT_CNT_W'(r_out_nsat) : '0;
        end else if (w_out_fire) begin
            w_sat_cnt = w_sum[SAT_CNT_W] ? SAT_CNT_MAX : w_sum[SAT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_relu  <= 1'b0;
            r_s1_data  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_relu <= relu_en;
                r_s1_data <= w_s1_data;
            end
        end
    end

    // Output register doubles as S2; it holds while stalled by the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_nsat  <= '0;
        end else if (w_out_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_out_data;
                r_out_nsat <= w_nsat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else begin
            r_sat_cnt <= w_sat_cnt;
        end
    end

endmodule

// File: tb/tb_quantize_pipe.sv
// Scoreboard bench for quantize_pipe: random and directed beats against an arithmetic model.
module tb_quantize_pipe;

    localparam int AS  = 8;
    localparam int DW  = 8;
    localparam int CBE = 5;
    localparam int ORI = DW * 2 + CBE;
    localparam int OW  = 16;
    localparam int SW  = 4;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [AS*ORI-1:0]   ori_data = '0;
    logic [SW-1:0]       shift_amt = '0;
    logic                relu_en = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [AS*OW-1:0]    quantized_data;
    logic [15:0]         sat_cnt;
    logic                sat_clr = 1'b0;

    quantize_pipe #(
        .ARRAY_SIZE        (AS),
        .DATA_WIDTH        (DW),
        .CUM_BITS_EXT      (CBE),
        .ORI_WIDTH         (ORI),
        .OUTPUT_DATA_WIDTH (OW),
        .SHIFT_WIDTH       (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ori_data       (ori_data),
        .shift_amt      (shift_amt),
        .relu_en        (relu_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .quantized_data (quantized_data),
        .sat_cnt        (sat_cnt),
        .sat_clr        (sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AS*OW-1:0] data;
        int               nsat;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    longint           model_cnt = 0;
    int               rdy_mode = 0;
    int               pat_idx = 0;
    bit               prev_stall = 0;
    logic [AS*OW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Round half up: floor((x + d/2) / d), then ReLU, then clamp to the output range.
    function automatic exp_t model(input logic [AS*ORI-1:0] d, input int s, input bit r);
        exp_t        e;
        longint      x, y, t, dv;
        logic [63:0] yb;
        e.data = '0;
        e.nsat = 0;
        for (int i = 0; i < AS; i++) begin
            x = longint'($signed(d[i*ORI +: ORI]));
            if (s == 0) begin
                y = x;
            end else if (s >= ORI) begin
                y = (x < 0) ? -1 : 0;
            end else begin
                dv = longint'(1) << s;
                t  = x + dv / 2;
                y  = t / dv;
                if ((t % dv) != 0 && t < 0) y = y - 1;
            end
            if (r && y < 0) y = 0;
            if (y > MAXV) begin
                y = MAXV;
                e.nsat++;
            end else if (y < MINV) begin
                y = MINV;
                e.nsat++;
            end
            yb = y;
            e.data[i*OW +: OW] = yb[OW-1:0];
        end
        return e;
    endfunction

    function automatic logic [AS*ORI-1:0] put(input logic [AS*ORI-1:0] d, input int i,
                                              input longint v);
        logic [63:0] vb;
        vb = v;
        d[i*ORI +: ORI] = vb[ORI-1:0];
        return d;
    endfunction

    function automatic logic [AS*ORI-1:0] rand_beat();
        logic [AS*ORI-1:0] d;
        d = '0;
        for (int i = 0; i < AS; i++) begin
            case ($urandom_range(0, 2))
                0:       d = put(d, i, longint'($urandom_range(0, 2000)) - 1000);
                1:       d = put(d, i, longint'($urandom_range(0, 2097151)) - 1048576);
                default: d = put(d, i, longint'($urandom_range(0, 200000)) - 100000);
            endcase
        end
        return d;
    endfunction

    function automatic logic [AS*ORI-1:0] sat_beat(input int nlanes);
        logic [AS*ORI-1:0] d;
        longint            v;
        d = '0;
        for (int i = 0; i < nlanes; i++) begin
            v = 40000 + longint'($urandom_range(0, 900000));
            if ($urandom_range(0, 1) == 1) v = -v;
            d = put(d, i, v);
        end
        return d;
    endfunction

    task automatic send(input logic [AS*ORI-1:0] d, input int s, input bit r);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        ori_data  = d;
        shift_amt = SW'(s);
        relu_en   = r;
        in_valid  = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready && rst_n;
            @(posedge clk);
            if (acc) sb.push_back(model(d, s, r));
            #1;
            if (!acc) begin
                n++;
                if (n > 1000) begin
                    check("send_timeout", 1, 0);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                check("drain_timeout", sb.size(), 0);
                sb.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end
            2: out_ready = ($urandom_range(0, 2) != 0);
            default: ;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        int   nsat;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            check("sat_cnt", sat_cnt, model_cnt);
            check("in_ready", in_ready, !(sb.size() >= 2 && !out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", quantized_data, prev_data);
            end
            hs = out_valid && out_ready;
            nsat = 0;
            if (hs) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data", quantized_data, e.data);
                    nsat = e.nsat;
                end
            end
            if (sat_clr) model_cnt = hs ? nsat : 0;
            else if (hs) model_cnt = (model_cnt + nsat > 65535) ? 65535 : model_cnt + nsat;
            prev_stall = out_valid && !out_ready;
            prev_data  = quantized_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [AS*ORI-1:0] d;
        logic [15:0]       c0;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_data", quantized_data, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and rounding examples
        rdy_mode = 0;
        send(put('0, 0, 1000), 4, 0);
        check("latency_1", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_2", out_valid, 1);
        check("lane0_1000_s4", quantized_data[15:0], 16'd63);
        send(put('0, 1, -24), 3, 0);
        @(posedge clk);
        #1;
        check("lane1_m24_s3", quantized_data[31:16], 16'hFFFD);
        drain();

        // Saturation at both rails; exact max is not saturated
        c0 = sat_cnt;
        d = put(put(put('0, 0, 40000), 1, -40000), 2, 32767);
        send(d, 0, 0);
        drain();
        check("sat_inc_2", sat_cnt, c0 + 16'd2);
        check("sat_hi", quantized_data[15:0], 16'h7FFF);
        check("sat_lo", quantized_data[31:16], 16'h8000);
        check("exact_max", quantized_data[47:32], 16'h7FFF);

        // ReLU
        send(put(put('0, 0, -500), 1, 500), 2, 1);
        drain();
        check("relu_neg", quantized_data[15:0], 16'd0);
        check("relu_pos", quantized_data[31:16], 16'd125);

        // Stream under a 1-0-0-1 consumer pattern
        rdy_mode = 1;
        pat_idx = 0;
        for (int i = 0; i < 10; i++) send(rand_beat(), $urandom_range(0, 15), $urandom_range(0, 1));
        drain();

        // Random traffic, random backpressure and clears
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            sat_clr = ($urandom_range(0, 15) == 0);
            send(rand_beat(), $urandom_range(0, 15), $urandom_range(0, 1));
            sat_clr = 1'b0;
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Clear coincident with a 3-lane saturating handshake
        send(sat_beat(3), 0, 0);
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("clr_coincident", sat_cnt, 16'd3);
        drain();

        // Fill to 16'hFFFE, then cross the ceiling
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        for (int i = 0; i < 8191; i++) send(sat_beat(8), 0, 0);
        send(sat_beat(6), 0, 0);
        drain();
        check("preload_fffe", sat_cnt, 16'hFFFE);
        send(sat_beat(4), 0, 0);
        drain();
        check("clamp_ffff", sat_cnt, 16'hFFFF);
        send(sat_beat(8), 0, 0);
        drain();
        check("sticky_ffff", sat_cnt, 16'hFFFF);

        // Reset with two beats in flight
        rdy_mode = 3;
        out_ready = 1'b0;
        send(rand_beat(), 0, 0);
        send(rand_beat(), 0, 0);
        check("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sat_cnt", sat_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_data", quantized_data, 0);
        sb.delete();
        model_cnt = 0;
        prev_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(put('0, 0, 1000), 4, 0);
        check("post_rst_lat_1", out_valid, 0);
        @(posedge clk);
        #1;
        check("post_rst_lat_2", out_valid, 1);
        check("post_rst_lane0", quantized_data[15:0], 16'd63);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
